// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / next-PC stage: holds the PC and the NZCV flags, fetches over a
// req/ack port, and commits the branch/flag decision when the datapath advances.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        Branch,
  input  logic        cbz,
  input  logic        blt,
  input  logic        bl,
  input  logic        br,
  input  logic        setFlag,
  input  logic [63:0] imm,
  input  logic [63:0] br_target,
  input  logic        zero,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic [63:0] pc,
  output logic [63:0] link_addr
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, state_n;
  logic [63:0] pc_n, next_pc, seq_pc, tgt_pc;
  logic [3:0]  flags_n;
  logic [31:0] instr_n;
  logic        lt;

  // BL differs from B only in the link write, which the datapath takes from link_addr.
  logic unused_bl;
  assign unused_bl = bl;

  assign seq_pc    = pc + 64'd4;
  assign tgt_pc    = pc + (imm << 2);
  assign lt        = flags[3] ^ flags[0];
  assign link_addr = seq_pc;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) && !reset;

  always_comb begin
    next_pc = seq_pc;
    if (br)
      next_pc = br_target;
    else if (Branch && cbz)
      next_pc = zero ? tgt_pc : seq_pc;
    else if (Branch && blt)
      next_pc = lt ? tgt_pc : seq_pc;
    else if (Branch)
      next_pc = tgt_pc;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    flags_n = flags;
    instr_n = instruction;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (advance) begin
          pc_n = next_pc;
          if (setFlag)
            flags_n = alu_flags;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      flags       <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      flags       <= flags_n;
      instruction <= instr_n;
      instr_valid <= (state_n == EXEC);
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: hand-computed PC/flag sequences checked with
// immediate assertions one step after each rising edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance = 1'b0;
  logic        Branch = 1'b0, cbz = 1'b0, blt = 1'b0, bl = 1'b0, br = 1'b0, setFlag = 1'b0;
  logic [63:0] imm = '0;
  logic [63:0] br_target = '0;
  logic        zero = 1'b0;
  logic [3:0]  alu_flags = '0;
  logic [3:0]  flags;
  logic [63:0] pc;
  logic [63:0] link_addr;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instruction(instruction),
    .instr_valid(instr_valid), .advance(advance), .Branch(Branch), .cbz(cbz),
    .blt(blt), .bl(bl), .br(br), .setFlag(setFlag), .imm(imm), .br_target(br_target),
    .zero(zero), .alu_flags(alu_flags), .flags(flags), .pc(pc), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    Branch = 0; cbz = 0; blt = 0; bl = 0; br = 0; setFlag = 0;
    imm = '0; br_target = '0; zero = 0; alu_flags = '0;
  endtask

  // Fetch at exp_addr with the ack arriving k cycles after the request; ends in EXEC.
  task automatic run_instr(input logic [63:0] exp_addr, input logic [31:0] word, input int k);
    for (int i = 0; i < k; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, exp_addr);
      chk("wait_iv", instr_valid, 0);
      tick();
    end
    chk("req", imem_req, 1);
    chk("addr", imem_addr, exp_addr);
    imem_ack = 1; imem_rdata = word;
    tick();
    imem_ack = 0;
    chk("exec_iv", instr_valid, 1);
    chk("exec_instr", instruction, {32'h0, word});
    chk("exec_req", imem_req, 0);
  endtask

  // Commit the current instruction with the controls already applied; check the new pc.
  task automatic exec_adv(input logic [63:0] exp_pc);
    advance = 1;
    tick();
    advance = 0;
    clr_ctl();
    chk("adv_iv", instr_valid, 0);
    chk("adv_pc", pc, exp_pc);
    chk("adv_addr", imem_addr, exp_pc);
  endtask

  initial begin
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_flags", flags, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_iv", instr_valid, 0);
    tick();
    reset = 0;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 64'h0);

    // sequential fetch, immediate ack and advance
    run_instr(64'd0, 32'hD503201F, 0);  exec_adv(64'd4);
    run_instr(64'd4, 32'hD503201F, 0);  exec_adv(64'd8);

    // ack delayed 3 cycles, advance held low 2 cycles, stray ack in EXEC ignored
    run_instr(64'd8, 32'h8B020020, 3);
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("hold1_pc", pc, 64'd8);
    chk("hold1_instr", instruction, 32'h8B020020);
    chk("hold1_iv", instr_valid, 1);
    tick();
    imem_ack = 0;
    chk("hold2_pc", pc, 64'd8);
    chk("hold2_instr", instruction, 32'h8B020020);
    exec_adv(64'd12);

    run_instr(64'd12, 32'hD503201F, 0); exec_adv(64'd16);
    chk("flags_zero", flags, 0);

    // B imm=-2 at 16 -> 8, then B imm=2 back to 16
    run_instr(64'd16, 32'h17FFFFFE, 0); Branch = 1; imm = -64'sd2; exec_adv(64'd8);
    run_instr(64'd8, 32'h14000002, 0);  Branch = 1; imm = 64'd2;   exec_adv(64'd16);

    // BL imm=5 at 16
    run_instr(64'd16, 32'h94000005, 0);
    chk("bl_link", link_addr, 64'd20);
    Branch = 1; bl = 1; imm = 64'd5;
    exec_adv(64'd36);

    run_instr(64'd36, 32'hD503201F, 0); exec_adv(64'd40);

    // CBZ taken / not taken
    run_instr(64'd40, 32'hB4000060, 0); Branch = 1; cbz = 1; zero = 1; imm = 64'd3; exec_adv(64'd52);
    run_instr(64'd52, 32'h17FFFFFD, 0); Branch = 1; imm = -64'sd3; exec_adv(64'd40);
    run_instr(64'd40, 32'hB4000060, 0); Branch = 1; cbz = 1; zero = 0; imm = 64'd3; exec_adv(64'd44);

    // SUBS sets N, B.LT taken using stored flags (alu_flags ignored)
    run_instr(64'd44, 32'hEB020020, 0); setFlag = 1; alu_flags = 4'b1000; exec_adv(64'd48);
    chk("flags_n", flags, 4'b1000);
    run_instr(64'd48, 32'h5400008B, 0); Branch = 1; blt = 1; imm = 64'd4; exec_adv(64'd64);

    // N=V -> B.LT not taken
    run_instr(64'd64, 32'hEB020020, 0); setFlag = 1; alu_flags = 4'b1001; exec_adv(64'd68);
    chk("flags_nv", flags, 4'b1001);
    run_instr(64'd68, 32'h5400008B, 0); Branch = 1; blt = 1; imm = 64'd4; exec_adv(64'd72);

    // B.LT with setFlag in the same EXEC sees the old flags
    run_instr(64'd72, 32'h5400008B, 0);
    Branch = 1; blt = 1; imm = 64'd4; setFlag = 1; alu_flags = 4'b1000;
    exec_adv(64'd76);
    chk("flags_after_same", flags, 4'b1000);

    // BR has priority over Branch
    run_instr(64'd76, 32'hD61F0000, 0);
    br = 1; br_target = 64'h100; Branch = 1; imm = 64'd8;
    exec_adv(64'h100);

    // wrap-around at the top of the address space
    run_instr(64'h100, 32'hD61F0000, 0); br = 1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    exec_adv(64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(64'hFFFF_FFFF_FFFF_FFFC, 32'hD503201F, 0);
    chk("wrap_link", link_addr, 64'h0);
    exec_adv(64'h0);
    run_instr(64'd0, 32'hD503201F, 0); exec_adv(64'd4);

    // reset mid-fetch
    chk("mf_addr", imem_addr, 64'd4);
    reset = 1;
    #1;
    chk("mf_req", imem_req, 0);
    chk("mf_pc", pc, 64'h0);
    tick();
    reset = 0;
    #1;
    chk("mf_restart_req", imem_req, 1);
    chk("mf_restart_addr", imem_addr, 64'h0);

    // reset mid-EXEC with advance pending: no commit, late ack ignored
    run_instr(64'd0, 32'h12345678, 0);
    advance = 1; setFlag = 1; alu_flags = 4'b0111; Branch = 1; imm = 64'd10;
    reset = 1;
    #1;
    chk("me_iv", instr_valid, 0);
    chk("me_pc", pc, 64'h0);
    chk("me_flags", flags, 0);
    imem_ack = 1; imem_rdata = 32'hCAFEF00D;
    tick();
    chk("me_pc2", pc, 64'h0);
    chk("me_flags2", flags, 0);
    chk("me_instr", instruction, 0);
    chk("me_req", imem_req, 0);
    advance = 0; clr_ctl(); imem_ack = 0;
    reset = 0;
    #1;
    chk("me_restart_req", imem_req, 1);
    chk("me_restart_iv", instr_valid, 0);
    run_instr(64'd0, 32'hD503201F, 0); exec_adv(64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
